dll_tx_dllp_gen: RTL
====================

Name: dll_tx_dllp_gen

Overview:
- Data Link Layer DLLP source, directly upstream of the TX arbiter's DLLP input.
- Turns Ack/Nak requests from the RX sequence checker and flow-control credit state from the TL RX buffers into 48-bit DLLPs: 4 content bytes plus CRC-16.
- Schedules DLLPs by priority with Ack coalescing and periodic UpdateFC refresh.
- Holds each DLLP stable until the downstream TX path accepts it.

Parameters:
- ACK_LAT, 16, cycles an Ack may stay pending before it is forced out (coalescing window).
- FC_UPD_PERIOD, 1024, cycles between forced UpdateFC refreshes of all three credit types.
- CNT_W, 16, width of the internal timers; must satisfy 2^CNT_W > max(ACK_LAT, FC_UPD_PERIOD).

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- link_up_i  in  1  DL_Active; when 0, all pending requests are cleared and no DLLP is issued
- ack_req_i  in  1  one-cycle pulse: schedule an Ack
- nak_req_i  in  1  one-cycle pulse: schedule a Nak
- ack_seq_i  in  12  sequence number carried by the Ack/Nak; sampled with ack_req_i/nak_req_i
- fc_p_hdr_i / fc_np_hdr_i / fc_cpl_hdr_i  in  8 each  current HdrFC credits per type
- fc_p_data_i / fc_np_data_i / fc_cpl_data_i  in  12 each  current DataFC credits per type
- dllp_o  out  48  DLLP to the arbiter's DLLP input
- dllp_valid_o  out  1  dllp_o valid
- dllp_ready_i  in  1  downstream accepts dllp_o this cycle

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-high.
- Reset values: dllp_o=0, dllp_valid_o=0, all pending flags=0, timers=0, stored seq=0, credit shadows=0.
- DLLP byte layout:
  - dllp_o[7:0]=byte0 (type); [15:8]=byte1; [23:16]=byte2; [31:24]=byte3; [47:32]=CRC.
  - Ack: type 8'h00, bytes1..3 = {12'h000, seq[11:0]}.
  - Nak: type 8'h10, same payload.
  - UpdateFC: type 8'h80 (P), 8'h90 (NP), 8'hA0 (Cpl), VC0; bytes1..3 = {2'b00, HdrFC[7:0], 2'b00, DataFC[11:0]}.
- CRC:
  - CRC-16, polynomial 16'h100B, init 16'hFFFF.
  - Input is the 32 content bits, byte0 first, each byte LSB first.
  - Result is complemented and bit-reversed per byte.
- Pending logic:
  - nak_req_i: set nak_pend, store seq, clear ack_pend (the Nak carries the acknowledgement).
  - ack_req_i with nak_pend=0: set ack_pend, overwrite seq (coalescing). Restart the ack timer only if ack_pend was 0.
  - ack_req_i with nak_pend=1: update seq only.
  - nak_req_i and ack_req_i in the same cycle: treated as nak_req_i alone.
  - Credit change: any change between an fc input and its shadow sets that type's fc_pend and updates the shadow.
  - Periodic refresh: fc timer reaching FC_UPD_PERIOD-1 sets all three fc_pend and wraps the timer to 0.
  - ack_rdy = ack_pend && (ack timer ≥ ACK_LAT-1). The ack timer saturates.
- FSM:
  - IDLE: if link_up_i and any request is eligible, select by priority Nak > Ack(ack_rdy) > FC-P > FC-NP > FC-Cpl. Register dllp_o (content + CRC), assert dllp_valid_o next cycle, clear the selected pending flag, go to HOLD.
  - HOLD: dllp_o and dllp_valid_o stay stable while dllp_ready_i=0.
  - On dllp_valid_o && dllp_ready_i: go to IDLE, dllp_valid_o=0 next cycle.
  - Minimum spacing is therefore 2 cycles per DLLP.
- Requests during HOLD: new requests and seq updates only change pending state. The held DLLP is never altered.
- link_up_i=0: all pending flags cleared, timers held at 0, FSM forced to IDLE, dllp_valid_o=0 next cycle (an in-flight DLLP is dropped).
- link_up_i rising: all three fc_pend are set (initial UpdateFC burst).
- Latency: a Nak pulse in cycle N with FSM IDLE gives dllp_valid_o=1 in cycle N+2 (pend registered at N+1, output registered at N+2).

Decomposition:
- Shared package dll_pkg:
  - DLLP type encodings: DLLP_ACK, DLLP_NAK, DLLP_UFC_P, DLLP_UFC_NP, DLLP_UFC_CPL.
  - dllp_t packed struct for the 48-bit layout.
  - CRC16 polynomial and init constants.
- Sub-module dll_crc16: purely combinational, 32-bit in, 16-bit out; reused by the RX DLLP checker.

Test Plan:
- Nak priority: link up, FC idle; nak_req_i with seq=12'h123 → dllp_o[31:0]=32'h2301_0010 held under ready=0 for 5 cycles, then released on ready=1; CRC matches the bench reference model.
- Ack coalescing: ACK_LAT=16; ack_req_i with seq 5, then 6, then 7 within 10 cycles → exactly one Ack, seq=7, issued 16 cycles after the first request.
- Nak supersedes Ack: ack_req_i seq=9, then nak_req_i seq=8 before expiry → a single Nak with seq=8 and no Ack.
- FC change and ordering: change fc_np_hdr_i to 8'h20 and fc_p_data_i to 12'h040 in the same cycle → UFC-P first, then UFC-NP with the correct payloads; no Cpl DLLP.
- Periodic refresh: FC_UPD_PERIOD=64, inputs static → P, NP, Cpl UpdateFCs every 64 cycles, in that order.
- Reset and link-down: drop link_up_i while dllp_valid_o=1 and ready=0 → valid=0 next cycle, pending cleared. Assert rst mid-HOLD → outputs 0 immediately (asynchronous). On link_up_i rising → three UpdateFCs.

Source files
------------

// File: rtl/dll_pkg.sv
// Shared Data Link Layer definitions: DLLP encodings, 48-bit DLLP layout and CRC-16 constants.
// Used by the TX DLLP generator and the RX DLLP checker.
package dll_pkg;

  localparam logic [7:0] DLLP_ACK     = 8'h00;
  localparam logic [7:0] DLLP_NAK     = 8'h10;
  localparam logic [7:0] DLLP_UFC_P   = 8'h80;
  localparam logic [7:0] DLLP_UFC_NP  = 8'h90;
  localparam logic [7:0] DLLP_UFC_CPL = 8'hA0;

  localparam logic [15:0] CRC16_POLY = 16'h100B;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Wire order: b0 in the low byte, CRC in the top 16 bits
  typedef struct packed {
    logic [15:0] crc;
    logic [7:0]  b3;
    logic [7:0]  b2;
    logic [7:0]  b1;
    logic [7:0]  b0;
  } dllp_t;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } dllp_state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_NAK,
    SEL_ACK,
    SEL_P,
    SEL_NP,
    SEL_CPL
  } dllp_sel_t;

  // The 24-bit payload goes out most-significant byte first (in byte1)
  function automatic logic [31:0] dllp_content(input logic [7:0] typ, input logic [23:0] payload);
    return {payload[7:0], payload[15:8], payload[23:16], typ};
  endfunction

endpackage

// File: rtl/dll_tx_dllp_gen_if.sv
// DLLP valid/ready handshake between the DLLP generator and the TX arbiter.
interface dll_tx_dllp_gen_if;
  dll_pkg::dllp_t dllp_o;
  logic           dllp_valid_o;
  logic           dllp_ready_i;

  modport master (output dllp_o, output dllp_valid_o, input dllp_ready_i);
  modport slave  (input dllp_o, input dllp_valid_o, output dllp_ready_i);
endinterface

// File: rtl/dll_crc16.sv
// Combinational DLLP CRC-16 over 4 content bytes, byte0 first, each byte LSB first.
// Output is complemented and bit-reversed within each byte, ready to drop into dllp_t.crc.
module dll_crc16
  import dll_pkg::*;
(
  input  logic [31:0] i_data,
  output logic [15:0] o_crc
);

  logic [15:0] w_lfsr;

  always_comb begin
    w_lfsr = CRC16_INIT;
    for (int i = 0; i < 32; i++) begin
      if (w_lfsr[15] ^ i_data[i]) w_lfsr = {w_lfsr[14:0], 1'b0} ^ CRC16_POLY;
      else                        w_lfsr = {w_lfsr[14:0], 1'b0};
    end
  end

  always_comb begin
    o_crc = '0;
    for (int i = 0; i < 8; i++) begin
      o_crc[15-i] = ~w_lfsr[8+i];
      o_crc[7-i]  = ~w_lfsr[i];
    end
  end

endmodule

// File: rtl/dll_tx_dllp_gen.sv
// TX DLLP source: Nak > Ack > UFC-P > UFC-NP > UFC-Cpl, with Ack coalescing and periodic UpdateFC.
// state   | meaning
// ST_IDLE | no DLLP presented; loads the highest-priority eligible request
// ST_HOLD | dllp_o/dllp_valid_o held stable until dllp_ready_i
module dll_tx_dllp_gen
  import dll_pkg::*;
#(
  parameter int ACK_LAT       = 16,
  parameter int FC_UPD_PERIOD = 1024,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              link_up_i,
  input  logic              ack_req_i,
  input  logic              nak_req_i,
  input  logic [11:0]       ack_seq_i,
  input  logic [7:0]        fc_p_hdr_i,
  input  logic [7:0]        fc_np_hdr_i,
  input  logic [7:0]        fc_cpl_hdr_i,
  input  logic [11:0]       fc_p_data_i,
  input  logic [11:0]       fc_np_data_i,
  input  logic [11:0]       fc_cpl_data_i,
  dll_tx_dllp_gen_if.master dllp_bus
);

  localparam logic [CNT_W-1:0] ACK_THR = CNT_W'(ACK_LAT - 1);
  localparam logic [CNT_W-1:0] FC_THR  = CNT_W'(FC_UPD_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  dllp_state_t      r_state, w_state_nxt;
  logic             r_valid, w_valid_nxt;
  dllp_t            r_dllp, w_dllp_nxt;
  logic             r_link_q;
  logic             r_nak_pend, r_ack_pend;
  logic [11:0]      r_seq;
  logic [CNT_W-1:0] r_ack_tmr, r_fc_tmr;
  logic [2:0]       r_fc_pend;  // [0]=P [1]=NP [2]=Cpl
  logic [7:0]       r_p_hdr, r_np_hdr, r_cpl_hdr;
  logic [11:0]      r_p_data, r_np_data, r_cpl_data;

  dllp_sel_t        w_cand, w_sel;
  logic             w_ack_rdy, w_load, w_nak_keep, w_ack_keep, w_fc_tick;
  logic [2:0]       w_fc_chg, w_fc_keep;
  logic [31:0]      w_content;
  logic [15:0]      w_crc;

  assign w_ack_rdy = r_ack_pend && (r_ack_tmr >= ACK_THR);

  always_comb begin
    w_cand = SEL_NONE;
    if (r_nak_pend)        w_cand = SEL_NAK;
    else if (w_ack_rdy)    w_cand = SEL_ACK;
    else if (r_fc_pend[0]) w_cand = SEL_P;
    else if (r_fc_pend[1]) w_cand = SEL_NP;
    else if (r_fc_pend[2]) w_cand = SEL_CPL;
  end

  always_comb begin
    w_content = '0;
    case (w_cand)
      SEL_NAK: w_content = dllp_content(DLLP_NAK, {12'h000, r_seq});
      SEL_ACK: w_content = dllp_content(DLLP_ACK, {12'h000, r_seq});
      SEL_P:   w_content = dllp_content(DLLP_UFC_P, {2'b00, r_p_hdr, 2'b00, r_p_data});
      SEL_NP:  w_content = dllp_content(DLLP_UFC_NP, {2'b00, r_np_hdr, 2'b00, r_np_data});
      SEL_CPL: w_content = dllp_content(DLLP_UFC_CPL, {2'b00, r_cpl_hdr, 2'b00, r_cpl_data});
      default: w_content = '0;
    endcase
  end

  dll_crc16 u_crc (
    .i_data (w_content),
    .o_crc  (w_crc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_dllp_nxt  = r_dllp;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cand != SEL_NONE) begin
          w_load      = 1'b1;
          w_state_nxt = ST_HOLD;
          w_valid_nxt = 1'b1;
          w_dllp_nxt  = {w_crc, w_content};
        end
      end
      ST_HOLD: begin
        if (dllp_bus.dllp_ready_i) begin
          w_state_nxt = ST_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Link down drops any in-flight DLLP
    if (!link_up_i) begin
      w_state_nxt = ST_IDLE;
      w_valid_nxt = 1'b0;
      w_dllp_nxt  = r_dllp;
      w_load      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_dllp  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_dllp  <= w_dllp_nxt;
    end
  end

  assign dllp_bus.dllp_o       = r_dllp;
  assign dllp_bus.dllp_valid_o = r_valid;

  assign w_sel      = w_load ? w_cand : SEL_NONE;
  assign w_nak_keep = r_nak_pend && (w_sel != SEL_NAK);
  assign w_ack_keep = r_ack_pend && (w_sel != SEL_ACK);
  assign w_fc_keep  = r_fc_pend & ~{w_sel == SEL_CPL, w_sel == SEL_NP, w_sel == SEL_P};
  assign w_fc_chg   = {(fc_cpl_hdr_i != r_cpl_hdr) || (fc_cpl_data_i != r_cpl_data),
                       (fc_np_hdr_i  != r_np_hdr)  || (fc_np_data_i  != r_np_data),
                       (fc_p_hdr_i   != r_p_hdr)   || (fc_p_data_i   != r_p_data)};
  assign w_fc_tick  = (r_fc_tmr == FC_THR);

  // New requests win over the clear of a flag being consumed in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_link_q   <= 1'b0;
      r_nak_pend <= 1'b0;
      r_ack_pend <= 1'b0;
      r_fc_pend  <= '0;
      r_ack_tmr  <= '0;
      r_fc_tmr   <= '0;
      r_seq      <= '0;
      r_p_hdr    <= '0;
      r_np_hdr   <= '0;
      r_cpl_hdr  <= '0;
      r_p_data   <= '0;
      r_np_data  <= '0;
      r_cpl_data <= '0;
    end else begin
      r_link_q   <= link_up_i;
      r_p_hdr    <= fc_p_hdr_i;
      r_np_hdr   <= fc_np_hdr_i;
      r_cpl_hdr  <= fc_cpl_hdr_i;
      r_p_data   <= fc_p_data_i;
      r_np_data  <= fc_np_data_i;
      r_cpl_data <= fc_cpl_data_i;
      if (nak_req_i || ack_req_i) r_seq <= ack_seq_i;
      if (!link_up_i) begin
        r_nak_pend <= 1'b0;
        r_ack_pend <= 1'b0;
        r_fc_pend  <= '0;
        r_ack_tmr  <= '0;
        r_fc_tmr   <= '0;
      end else begin
        r_nak_pend <= nak_req_i || w_nak_keep;
        if (nak_req_i)                      r_ack_pend <= 1'b0;
        else if (ack_req_i && !w_nak_keep) r_ack_pend <= 1'b1;
        else                               r_ack_pend <= w_ack_keep;
        if (nak_req_i || !w_ack_keep)      r_ack_tmr <= '0;
        else if (r_ack_tmr != CNT_MAX)     r_ack_tmr <= r_ack_tmr + 1'b1;
        r_fc_pend <= w_fc_keep | w_fc_chg | {3{w_fc_tick || !r_link_q}};
        r_fc_tmr  <= w_fc_tick ? '0 : r_fc_tmr + 1'b1;
      end
    end
  end

endmodule
